// File: rtl/block_slot_writer_pkg.sv
// Shared types, register map and colour helpers for the block slot writer.
package block_slot_writer_pkg;

    localparam int unsigned SLOT_AW      = 14;
    localparam int unsigned SLOT_DW      = 32;
    localparam int unsigned SLOT_REG_BIT = 13;

    typedef enum logic [1:0] {
        OP_MOVE   = 2'b00,
        OP_FULL   = 2'b01,
        OP_BYPASS = 2'b10,
        OP_NOP    = 2'b11
    } op_e;

    localparam logic [1:0] REG_BYPASS = 2'b00;
    localparam logic [1:0] REG_X0     = 2'b01;
    localparam logic [1:0] REG_Y0     = 2'b10;
    localparam logic [1:0] REG_CTRL   = 2'b11;

    typedef struct packed {
        logic               cs;
        logic               write;
        logic [SLOT_AW-1:0] addr;
        logic [SLOT_DW-1:0] wr_data;
    } slot_bus_t;

    // Halve each of the three ch_w-bit channels packed in the low bits of c.
    function automatic logic [SLOT_DW-1:0] shade(input logic [SLOT_DW-1:0] c,
                                                 input int unsigned ch_w);
        logic [SLOT_DW-1:0] keep;
        keep = '1;
        for (int unsigned k = 0; k < 3; k++) begin
            keep &= ~(SLOT_DW'(1) << (k * ch_w + ch_w - 1));
        end
        return (c >> 1) & keep;
    endfunction

    function automatic logic [SLOT_AW-1:0] reg_addr(input logic [1:0] off);
        return (SLOT_AW'(1) << SLOT_REG_BIT) | SLOT_AW'(off);
    endfunction

endpackage

// File: rtl/block_pattern_gen.sv
// Row/col walker over one tile: yields the RAM address and pixel colour
// (shaded on the border) for the current step, and flags the last pixel.
module block_pattern_gen
    import block_slot_writer_pkg::*;
#(
    parameter int unsigned CD         = 12,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BLOCK_W    = 32,
    parameter int unsigned BLOCK_H    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step,
    input  logic [CD-1:0]         colour,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic [SLOT_DW-1:0]    data_c,
    output logic                  last_c
);

    localparam int unsigned CW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int unsigned RW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  col_end;
    logic                  row_end;
    logic                  border;

    assign col_end = (col_q == CW'(BLOCK_W - 1));
    assign row_end = (row_q == RW'(BLOCK_H - 1));
    assign border  = (row_q == '0) || row_end || (col_q == '0) || col_end;
    assign last_c  = col_end && row_end;
    assign addr_c  = addr_q;
    assign data_c  = border ? shade(SLOT_DW'(colour), CD / 3) : SLOT_DW'(colour);

    // Column runs fastest; the linear address tracks row*BLOCK_W+col.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (clear) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (step) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
            addr_q <= last_c ? '0 : addr_q + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/block_slot_writer.sv
// Bus initiator that fills a block sprite tile and/or programs the sprite
// core registers over its slot write interface from a single start command.
module block_slot_writer
    import block_slot_writer_pkg::*;
#(
    parameter int unsigned CD         = 12,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BLOCK_W    = 32,
    parameter int unsigned BLOCK_H    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [CD-1:0]        colour,
    input  logic [10:0]          x0_in,
    input  logic [10:0]          y0_in,
    input  logic [3:0]           ctrl_in,
    input  logic                 bypass_in,
    output logic                 cs,
    output logic                 write,
    output logic [SLOT_AW-1:0]   addr,
    output logic [SLOT_DW-1:0]   wr_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_W_BYP, ST_W_X0, ST_W_Y0, ST_W_CTRL, ST_DONE
    } state_e;

    state_e                 state_q, state_nxt;
    op_e                    op_q;
    logic [CD-1:0]          colour_q;
    logic [10:0]            x0_q, y0_q;
    logic [3:0]             ctrl_q;
    logic                   bypass_q;
    slot_bus_t              bus_q, bus_nxt;
    logic                   busy_q, done_q;
    logic                   accept;
    logic                   step;
    logic [ADDR_WIDTH-1:0]  pix_addr;
    logic [SLOT_DW-1:0]     pix_data;
    logic                   pix_last;

    assign accept = (state_q == ST_IDLE) && start;

    block_pattern_gen #(
        .CD         (CD),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_W    (BLOCK_W),
        .BLOCK_H    (BLOCK_H)
    ) u_pattern (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .step   (step),
        .colour (colour_q),
        .addr_c (pix_addr),
        .data_c (pix_data),
        .last_c (pix_last)
    );

    // Next state and the bus word to launch on the coming edge.
    always_comb begin
        state_nxt = state_q;
        bus_nxt   = '0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_e'(op))
                        OP_FULL:   state_nxt = ST_FILL;
                        OP_MOVE:   state_nxt = ST_W_X0;
                        OP_BYPASS: state_nxt = ST_W_BYP;
                        OP_NOP:    state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_FILL: begin
                bus_nxt.cs      = 1'b1;
                bus_nxt.write   = 1'b1;
                bus_nxt.addr    = SLOT_AW'(pix_addr);
                bus_nxt.wr_data = pix_data;
                step            = 1'b1;
                if (pix_last) state_nxt = ST_W_BYP;
            end
            ST_W_BYP: begin
                bus_nxt.cs      = 1'b1;
                bus_nxt.write   = 1'b1;
                bus_nxt.addr    = reg_addr(REG_BYPASS);
                bus_nxt.wr_data = SLOT_DW'((op_q == OP_BYPASS) ? bypass_q : 1'b0);
                state_nxt       = (op_q == OP_FULL) ? ST_W_X0 : ST_DONE;
            end
            ST_W_X0: begin
                bus_nxt.cs      = 1'b1;
                bus_nxt.write   = 1'b1;
                bus_nxt.addr    = reg_addr(REG_X0);
                bus_nxt.wr_data = SLOT_DW'(x0_q);
                state_nxt       = ST_W_Y0;
            end
            ST_W_Y0: begin
                bus_nxt.cs      = 1'b1;
                bus_nxt.write   = 1'b1;
                bus_nxt.addr    = reg_addr(REG_Y0);
                bus_nxt.wr_data = SLOT_DW'(y0_q);
                state_nxt       = (op_q == OP_FULL) ? ST_W_CTRL : ST_DONE;
            end
            ST_W_CTRL: begin
                bus_nxt.cs      = 1'b1;
                bus_nxt.write   = 1'b1;
                bus_nxt.addr    = reg_addr(REG_CTRL);
                bus_nxt.wr_data = SLOT_DW'(ctrl_q);
                state_nxt       = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            colour_q <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            ctrl_q   <= '0;
            bypass_q <= 1'b0;
            bus_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            bus_q   <= bus_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
            done_q  <= (state_q == ST_DONE);
            if (accept) begin
                op_q     <= op_e'(op);
                colour_q <= colour;
                x0_q     <= x0_in;
                y0_q     <= y0_in;
                ctrl_q   <= ctrl_in;
                bypass_q <= bypass_in;
            end
        end
    end

    assign cs      = bus_q.cs;
    assign write   = bus_q.write;
    assign addr    = bus_q.addr;
    assign wr_data = bus_q.wr_data;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_block_slot_writer.sv
// Directed table-driven bench for block_slot_writer with a 4x4 tile.
module tb_block_slot_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b11;
    logic [11:0] colour = '0;
    logic [10:0] x0_in = '0;
    logic [10:0] y0_in = '0;
    logic [3:0]  ctrl_in = '0;
    logic        bypass_in = 1'b0;
    logic        cs, write, busy, done;
    logic [13:0] addr;
    logic [31:0] wr_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  done_at;
    int  busy_err;
    int  extra_wr;

    block_slot_writer #(
        .CD(12), .ADDR_WIDTH(12), .BLOCK_W(4), .BLOCK_H(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .colour(colour),
        .x0_in(x0_in), .y0_in(y0_in), .ctrl_in(ctrl_in), .bypass_in(bypass_in),
        .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [13:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Expected FULL sequence: 16 RAM words (interior = addr 5,6,9,10) then registers.
    task automatic build_full(input logic [31:0] inner, input logic [31:0] edge_c,
                              input logic [31:0] x, input logic [31:0] y, input logic [31:0] ct);
        exp_q.delete();
        for (int i = 0; i < 16; i++)
            push_exp(14'(i), (i == 5 || i == 6 || i == 9 || i == 10) ? inner : edge_c);
        push_exp(14'h2000, 32'd0);
        push_exp(14'h2001, x);
        push_exp(14'h2002, y);
        push_exp(14'h2003, ct);
    endtask

    // Issue one command, then record every write until done (bounded).
    task automatic run_cmd(input logic [1:0] o, input logic [11:0] c, input logic [10:0] x,
                           input logic [10:0] y, input logic [3:0] ct, input logic b);
        wr_t w;
        got_q.delete();
        done_at  = -1;
        busy_err = 0;
        extra_wr = 0;
        @(negedge clk);
        op = o; colour = c; x0_in = x; y0_in = y; ctrl_in = ct; bypass_in = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (cs && write) begin
                w.addr = addr;
                w.data = wr_data;
                got_q.push_back(w);
            end
            if (done) begin
                if (busy) busy_err++;
                done_at = n;
                break;
            end else if (!busy) begin
                busy_err++;
            end
        end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (cs || write || done) extra_wr++;
        end
    endtask

    task automatic compare(input string name, input int done_req);
        check({name, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s data[%0d]", name, i), got_q[i].data, exp_q[i].data);
        end
        check({name, " done cycle"}, 32'(done_at), 32'(done_req));
        check({name, " busy window"}, 32'(busy_err), 32'd0);
        check({name, " quiet after done"}, 32'(extra_wr), 32'd0);
    endtask

    initial begin
        int guard;
        // Reset state
        repeat (2) @(negedge clk);
        check("reset cs", 32'(cs), 32'd0);
        check("reset write", 32'(write), 32'd0);
        check("reset addr", 32'(addr), 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle cs", 32'(cs), 32'd0);

        // FULL, colour F84: border 742
        build_full(32'hF84, 32'h742, 32'd100, 32'd40, 32'd3);
        run_cmd(2'b01, 12'hF84, 11'd100, 11'd40, 4'd3, 1'b0);
        compare("full_f84", 21);

        // MOVE to the x0 extreme
        exp_q.delete();
        push_exp(14'h2001, 32'd2047);
        push_exp(14'h2002, 32'd0);
        run_cmd(2'b00, 12'h0AB, 11'd2047, 11'd0, 4'd9, 1'b1);
        compare("move", 3);

        // BYPASS set to 1
        exp_q.delete();
        push_exp(14'h2000, 32'd1);
        run_cmd(2'b10, 12'h000, 11'd5, 11'd6, 4'd7, 1'b1);
        compare("bypass", 2);

        // NOP: done next cycle, no writes
        exp_q.delete();
        run_cmd(2'b11, 12'hFFF, 11'd1, 11'd1, 4'd1, 1'b1);
        compare("nop", 1);

        // start held and pulsed during FULL with a new x0: original command only
        build_full(32'hF84, 32'h742, 32'd100, 32'd40, 32'd3);
        fork
            run_cmd(2'b01, 12'hF84, 11'd100, 11'd40, 4'd3, 1'b0);
            begin
                repeat (2) @(negedge clk);
                start = 1'b1; x0_in = 11'd555; op = 2'b00;
                repeat (6) @(negedge clk);
                start = 1'b0;
                repeat (2) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
                start = 1'b1; colour = 12'h123;
                @(negedge clk);
                start = 1'b0;
            end
        join
        compare("full_restart_ignored", 21);

        // Reset asserted while pixel 7 is on the bus
        @(negedge clk);
        op = 2'b01; colour = 12'hF84; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (!(cs && addr == 14'd7) && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        check("reach pixel 7", 32'(guard < 50), 32'd1);
        reset = 1'b0;
        #1;
        check("mid reset cs", 32'(cs), 32'd0);
        check("mid reset write", 32'(write), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("held reset done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post reset done", 32'(done), 32'd0);

        // Fresh FULL, colour 111: border shades to 000
        build_full(32'h111, 32'h000, 32'd7, 32'd2046, 32'd15);
        run_cmd(2'b01, 12'h111, 11'd7, 11'd2046, 4'd15, 1'b0);
        compare("full_111", 21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
